// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and round-robin pick for the DDR user-port arbiter
package ddr_arb_pkg;
  localparam int MAX_REQ = 8;
  typedef enum logic {ARB, ISSUE} arb_state_t;
  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;
  // First set bit scanning from last+1 wraps at n; scanning backwards lets the earliest hit win.
  function automatic req_id_t rr_pick(input logic [MAX_REQ-1:0] eligible, input req_id_t last, input int n);
    req_id_t w;
    req_id_t idx;
    w = last;
    for (int k = n; k >= 1; k--) begin
      idx = req_id_t'((int'(last) + k) % n);
      if (eligible[idx]) w = idx;
    end
    return w;
  endfunction
endpackage

// File: rtl/ddr_arb_if.sv
// ddr_arb_if: requester-side and controller-side signals of the DDR port arbiter
interface ddr_arb_if #(
  parameter int N_REQ = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 128
);
  logic [N_REQ-1:0] req_valid, req_we, req_ready, rsp_valid;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] rsp_data, mem_wr_data, mem_rd_data;
  logic [ADDR_WIDTH-1:0] mem_wr_addr, mem_rd_addr;
  logic mem_wr_en, mem_rd_en, mem_wr_busy, mem_rd_busy, mem_rd_valid, err_orphan;
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, mem_wr_busy, mem_rd_busy, mem_rd_data, mem_rd_valid,
    output req_ready, rsp_valid, rsp_data, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, err_orphan
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_wr_busy, mem_rd_busy, mem_rd_data, mem_rd_valid,
    input req_ready, rsp_valid, rsp_data, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, err_orphan
  );
endinterface

// File: rtl/ddr_arb_tag_fifo.sv
// ddr_arb_tag_fifo: in-order FIFO of requester ids for outstanding reads
module ddr_arb_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(DEPTH);
  req_id_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin sharing of the MIG user port with in-order read routing.
// Optional per-requester statistics under DDR_ARB_STATS_EN.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 128,
  parameter int TAG_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  ddr_arb_if.slave bus
`ifdef DDR_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0] stat_wr_cnt,
  output logic [N_REQ*32-1:0] stat_rd_cnt
`endif
);
  localparam int IW = $clog2(N_REQ);
  arb_state_t state, state_n;
  req_id_t last, win, h_id, head;
  logic [IW-1:0] sel;
  logic [N_REQ-1:0] elig;
  logic grant, accept, tag_full, tag_empty, h_we;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [ADDR_WIDTH-1:0] addr_a [N_REQ];
  logic [DATA_WIDTH-1:0] data_a [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_a[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // A full tag FIFO blocks reads only; writes never return data.
  assign elig = bus.req_valid & (bus.req_we | {N_REQ{!tag_full}});
  assign win = rr_pick(MAX_REQ'(elig), last, N_REQ);
  assign sel = IW'(win);
  assign grant = state == ARB && |elig;
  assign bus.req_ready = grant ? N_REQ'(1) << sel : '0;
  assign bus.mem_wr_en = state == ISSUE && h_we && !bus.mem_wr_busy;
  assign bus.mem_rd_en = state == ISSUE && !h_we && !bus.mem_rd_busy;
  assign bus.mem_wr_addr = h_addr;
  assign bus.mem_rd_addr = h_addr;
  assign bus.mem_wr_data = h_wdata;
  assign accept = bus.mem_wr_en || bus.mem_rd_en;
  assign bus.rsp_valid = (bus.mem_rd_valid && !tag_empty) ? N_REQ'(1) << IW'(head) : '0;
  assign bus.rsp_data = bus.mem_rd_data;
  always_comb begin
    state_n = state;
    if (state == ARB && grant) state_n = ISSUE;
    if (state == ISSUE && accept) state_n = ARB;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= req_id_t'(N_REQ - 1);
      h_we <= 1'b0;
      h_addr <= '0;
      h_wdata <= '0;
      h_id <= '0;
    end else if (grant) begin
      last <= win;
      h_we <= bus.req_we[sel];
      h_addr <= addr_a[sel];
      h_wdata <= data_a[sel];
      h_id <= win;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.err_orphan <= 1'b0;
    else if (bus.mem_rd_valid && tag_empty) bus.err_orphan <= 1'b1;
  end
  ddr_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk(clk),
    .rst(rst),
    .push(bus.mem_rd_en),
    .pop(bus.mem_rd_valid),
    .din(h_id),
    .dout(head),
    .full(tag_full),
    .empty(tag_empty)
  );
`ifdef DDR_ARB_STATS_EN
  logic [31:0] wr_cnt [N_REQ];
  logic [31:0] rd_cnt [N_REQ];
  logic [IW-1:0] h_sel;
  assign h_sel = IW'(h_id);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_cnt[i] <= '0;
        rd_cnt[i] <= '0;
      end
    end else begin
      if (bus.mem_wr_en && wr_cnt[h_sel] != '1) wr_cnt[h_sel] <= wr_cnt[h_sel] + 32'd1;
      if (bus.mem_rd_en && rd_cnt[h_sel] != '1) rd_cnt[h_sel] <= rd_cnt[h_sel] + 32'd1;
    end
  end
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    assign stat_wr_cnt[i*32 +: 32] = wr_cnt[i];
    assign stat_rd_cnt[i*32 +: 32] = rd_cnt[i];
  end
`endif
endmodule
